// File: rtl/stream_packer.sv
// Packs RATIO narrow FWFT words into one wide word with flush and lane count.
// Optional STREAM_PACKER_MSB_FIRST_EN places the first word in the MSB lane.
module stream_packer #(
    parameter int unsigned IN_WIDTH = 32,
    parameter int unsigned RATIO    = 4,
    localparam int unsigned OUT_WIDTH  = IN_WIDTH * RATIO,
    localparam int unsigned LANE_WIDTH = $clog2(RATIO + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_empty_n,
    output logic                  s_read,
    input  logic [IN_WIDTH-1:0]   s_dout,
    input  logic                  flush,
    output logic                  pending,
    input  logic                  m_full_n,
    output logic                  m_write,
    output logic [OUT_WIDTH-1:0]  m_din,
    output logic [LANE_WIDTH-1:0] m_lanes
);

    localparam int unsigned CNT_WIDTH = $clog2(RATIO);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(RATIO - 1);

    logic [OUT_WIDTH-1:0] accum;
    logic [OUT_WIDTH-1:0] accum_with;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] lane;
    logic                 out_valid;
    logic                 out_free;
    logic                 last;
    logic                 flush_req;
    logic                 do_flush;
    logic                 accept;

    assign out_free  = !out_valid || m_full_n;
    assign last      = (count == LAST);
    assign flush_req = flush && (count != '0);
    assign s_read    = reset && s_empty_n && !flush_req && (!last || out_free);
    assign accept    = s_read && s_empty_n;
    assign do_flush  = flush_req && out_free;
    assign pending   = (count != '0);
    assign m_write   = out_valid;

`ifdef STREAM_PACKER_MSB_FIRST_EN
    assign lane = LAST - count;
`else
    assign lane = count;
`endif

    // Accumulator with the incoming word dropped into its lane.
    always_comb begin
        accum_with = accum;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (lane == CNT_WIDTH'(k)) begin
                accum_with[k*IN_WIDTH +: IN_WIDTH] = s_dout;
            end
        end
    end

    // Accumulator, lane counter and output register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            accum     <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            m_din     <= '0;
            m_lanes   <= '0;
        end else begin
            if (do_flush) begin
                m_din     <= accum;
                m_lanes   <= LANE_WIDTH'(count);
                out_valid <= 1'b1;
                count     <= '0;
                accum     <= '0;
            end else if (accept && last) begin
                m_din     <= accum_with;
                m_lanes   <= LANE_WIDTH'(RATIO);
                out_valid <= 1'b1;
                count     <= '0;
                accum     <= '0;
            end else begin
                if (accept) begin
                    accum <= accum_with;
                    count <= count + CNT_WIDTH'(1);
                end
                if (m_full_n) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_packer.sv
// Directed bench for stream_packer with IN_WIDTH=8, RATIO=4.
module tb_stream_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_empty_n;
    logic        s_read;
    logic [7:0]  s_dout;
    logic        flush;
    logic        pending;
    logic        m_full_n;
    logic        m_write;
    logic [31:0] m_din;
    logic [2:0]  m_lanes;

    int n_tests = 0;
    int n_fail  = 0;

    stream_packer #(.IN_WIDTH(8), .RATIO(4)) dut (
        .clk(clk), .reset(reset), .s_empty_n(s_empty_n), .s_read(s_read),
        .s_dout(s_dout), .flush(flush), .pending(pending), .m_full_n(m_full_n),
        .m_write(m_write), .m_din(m_din), .m_lanes(m_lanes)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word, confirm it is popped, then withdraw it.
    task automatic feed(input logic [7:0] w);
        s_empty_n = 1'b1;
        s_dout    = w;
        #1;
        check("s_read_on_feed", 32'(s_read), 32'd1);
        tick();
        s_empty_n = 1'b0;
    endtask

    // Expected packed word holding the first n words.
    function automatic logic [31:0] pk(input logic [7:0] w0, w1, w2, w3, input int n);
        logic [7:0] w [4];
        logic [31:0] r;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        r = '0;
        for (int i = 0; i < n; i++) begin
`ifdef STREAM_PACKER_MSB_FIRST_EN
            r[(3-i)*8 +: 8] = w[i];
`else
            r[i*8 +: 8] = w[i];
`endif
        end
        return r;
    endfunction

    initial begin
        reset = 1'b0; s_empty_n = 1'b1; s_dout = 8'h5A; flush = 1'b0; m_full_n = 1'b1;
        tick(); tick();
        check("rst_s_read", 32'(s_read), 32'd0);
        check("rst_m_write", 32'(m_write), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_m_din", m_din, 32'd0);
        check("rst_m_lanes", 32'(m_lanes), 32'd0);
        s_empty_n = 1'b0;
        reset = 1'b1;
        tick();

        // Basic pack
        feed(8'h11); feed(8'h22); feed(8'h33);
        check("basic_no_early_write", 32'(m_write), 32'd0);
        check("basic_pending", 32'(pending), 32'd1);
        feed(8'h44);
        check("basic_m_write", 32'(m_write), 32'd1);
        check("basic_m_din", m_din, pk(8'h11, 8'h22, 8'h33, 8'h44, 4));
        check("basic_m_lanes", 32'(m_lanes), 32'd4);
        check("basic_pending_clr", 32'(pending), 32'd0);
        tick();
        check("basic_drained", 32'(m_write), 32'd0);

        // Streaming
        for (int i = 1; i <= 8; i++) begin
            feed(8'(i));
            if (i == 4) begin
                check("stream_w1_valid", 32'(m_write), 32'd1);
                check("stream_w1", m_din, pk(8'h01, 8'h02, 8'h03, 8'h04, 4));
            end
            if (i == 5) check("stream_gap", 32'(m_write), 32'd0);
            if (i == 8) begin
                check("stream_w2_valid", 32'(m_write), 32'd1);
                check("stream_w2", m_din, pk(8'h05, 8'h06, 8'h07, 8'h08, 4));
            end
        end
        tick();

        // Backpressure
        m_full_n = 1'b0;
        feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
        feed(8'h55); feed(8'h66); feed(8'h77);
        s_empty_n = 1'b1; s_dout = 8'h88;
        #1;
        check("bp_s_read_low", 32'(s_read), 32'd0);
        check("bp_m_din_held", m_din, pk(8'h11, 8'h22, 8'h33, 8'h44, 4));
        tick();
        check("bp_m_din_stable", m_din, pk(8'h11, 8'h22, 8'h33, 8'h44, 4));
        check("bp_m_write_held", 32'(m_write), 32'd1);
        m_full_n = 1'b1;
        #1;
        check("bp_s_read_release", 32'(s_read), 32'd1);
        tick();
        s_empty_n = 1'b0;
        check("bp_m_write_kept", 32'(m_write), 32'd1);
        check("bp_new_word", m_din, pk(8'h55, 8'h66, 8'h77, 8'h88, 4));
        tick();
        check("bp_drained", 32'(m_write), 32'd0);

        // Flush
        feed(8'hAA); feed(8'hBB);
        flush = 1'b1; s_empty_n = 1'b1; s_dout = 8'hCC;
        #1;
        check("flush_s_read_low", 32'(s_read), 32'd0);
        tick();
        flush = 1'b0; s_empty_n = 1'b0;
        check("flush_m_write", 32'(m_write), 32'd1);
        check("flush_m_din", m_din, pk(8'hAA, 8'hBB, 8'h00, 8'h00, 2));
        check("flush_m_lanes", 32'(m_lanes), 32'd2);
        check("flush_pending", 32'(pending), 32'd0);
        tick();
        check("flush_drained", 32'(m_write), 32'd0);
        flush = 1'b1;
        tick();
        check("flush_empty_no_write", 32'(m_write), 32'd0);
        feed(8'hCC);
        check("flush_c0_accept_pending", 32'(pending), 32'd1);
        check("flush_c0_no_write", 32'(m_write), 32'd0);
        tick();
        flush = 1'b0;
        check("flush_one_m_din", m_din, pk(8'hCC, 8'h00, 8'h00, 8'h00, 1));
        check("flush_one_m_lanes", 32'(m_lanes), 32'd1);
        tick();

        // Flush blocked while the output register is occupied
        m_full_n = 1'b0;
        feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
        feed(8'h99);
        flush = 1'b1;
        tick();
        check("flush_bp_m_din_held", m_din, pk(8'h01, 8'h02, 8'h03, 8'h04, 4));
        check("flush_bp_pending", 32'(pending), 32'd1);
        m_full_n = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_bp_m_din", m_din, pk(8'h99, 8'h00, 8'h00, 8'h00, 1));
        check("flush_bp_m_lanes", 32'(m_lanes), 32'd1);
        tick();
        check("flush_bp_drained", 32'(m_write), 32'd0);

        // Reset mid-operation
        feed(8'h01); feed(8'h02);
        reset = 1'b0; s_empty_n = 1'b1; s_dout = 8'h03;
        #1;
        check("mrst_s_read", 32'(s_read), 32'd0);
        tick();
        s_empty_n = 1'b0;
        check("mrst_m_write", 32'(m_write), 32'd0);
        check("mrst_pending", 32'(pending), 32'd0);
        reset = 1'b1;
        feed(8'h11); feed(8'h22); feed(8'h33);
        check("mrst_no_early", 32'(m_write), 32'd0);
        feed(8'h44);
        check("mrst_m_write_after", 32'(m_write), 32'd1);
        check("mrst_m_din", m_din, pk(8'h11, 8'h22, 8'h33, 8'h44, 4));
        tick();
        check("mrst_single", 32'(m_write), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
